ysyx_22040386_wb_commit: RTL and testbench
==========================================

// Module: ysyx_22040386_wb_commit
// PURPOSE
//  Parametrised, registered write-back/commit stage; successor to the combinational WBU. Sits between MEM and
//  the regfile/CSR file. Buffers MEM results in a small FIFO, merges CSR read data into GPR writes,
//  arbitrates timer-interrupt/ecall/mret per entry, emits one registered commit per cycle and counts instret.
// PARAMETERS
//  XLEN    64  datapath width (pc, GPR/CSR data)
//  RA_W    5   GPR address width
//  CA_W    12  CSR address width
//  DEPTH   2   input FIFO entries, power of two, >=2
//  CNT_W   64  instret counter width
// PORTS
//  i_clk          in   1      clock
//  i_rst_n        in   1      async active-low reset
//  i_valid        in   1      MEM entry valid
//  o_ready        out  1      FIFO can accept (not full)
//  i_inst         in   32     instruction (test)
//  i_pc           in   XLEN   entry pc
//  i_RegWrite     in   1      GPR write request
//  i_reg_wr_addr  in   RA_W   GPR dest
//  i_reg_wr_data  in   XLEN   ALU/load result
//  i_csr_RegWrite in   1      GPR gets CSR old value
//  i_csr_rdata    in   XLEN   CSR old value
//  i_csr_wen      in   1      CSR write request
//  i_csr_waddr    in   CA_W   CSR address
//  i_csr_wdata    in   XLEN   CSR new value
//  i_timer_intr   in   1      interrupt taken on this entry
//  i_ecall        in   1      ecall
//  i_mret         in   1      mret
//  i_trap_pc      in   XLEN   pc to record in mepc
//  i_stall        in   1      commit hold (difftest/CSR busy)
//  o_RegWrite / o_reg_wr_addr / o_reg_wr_data   out 1/RA_W/XLEN  GPR write port
//  o_csr_wen / o_csr_waddr / o_csr_wdata        out 1/CA_W/XLEN  CSR write port
//  o_timer_intr / o_ecall / o_mret              out 1 each       trap events, one-hot
//  o_trap_pc      out  XLEN   mepc value for trap
//  o_flush        out  1      pulse: younger pipeline must be squashed
//  o_commit       out  1      instruction retired this cycle
//  o_pc / o_inst  out  XLEN/32  retired pc/inst (to main.cpp)
//  o_instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty (o_ready=1), o_instret=0; reset mid-operation discards FIFO and output regs.
//  - Enqueue when i_valid&&o_ready; o_ready = !full (combinational from pointers). Pointers wrap mod DEPTH.
//  - Dequeue when !empty && !i_stall; all outputs registered: head entry appears 1 cycle after dequeue.
//    Min latency enqueue->o_commit = 2 cycles (FIFO write, then output reg). Full throughput 1/cycle.
//  - Enqueue and dequeue same cycle when full: dequeue frees slot only next cycle (o_ready stays 0).
//  - i_stall=1: output regs hold previous values but o_commit,o_RegWrite,o_csr_wen, trap outputs forced 0.
//  - Per-entry priority: timer_intr > ecall > mret > normal.
//    timer_intr: no GPR/CSR write, o_timer_intr=1, o_trap_pc=i_trap_pc, o_commit=0 (not retired), o_flush=1.
//    ecall: no GPR write, o_ecall=1, o_trap_pc=entry trap_pc, o_commit=1, o_flush=1.
//    mret: o_mret=1, o_commit=1, o_flush=1.
//    normal: o_reg_wr_data = csr_RegWrite ? csr_rdata : reg_wr_data; o_RegWrite=(RegWrite||csr_RegWrite)
//    && addr!=0; o_csr_wen=i_csr_wen.
//  - Flush: in the dequeue cycle of a trap/mret entry, all other FIFO entries and any same-cycle enqueue
//    are dropped; FIFO empty next cycle.
//  - o_instret += 1 per o_commit; wraps at 2^CNT_W.
// STRUCTURE
//  - Shared pkg ysyx_22040386_pkg: wb_entry_t struct (all i_* payload fields), XLEN/RA_W/CA_W defaults,
//    trap priority enum {TR_NONE,TR_MRET,TR_ECALL,TR_INTR}.
//  - One sub-module: ysyx_22040386_sync_fifo (DEPTH, entry type, push/pop/flush/full/empty).
// TESTING
//  - Reset then 3 back-to-back normal writes x5=1,x6=2,x7=3 -> o_RegWrite on cycles 2,3,4, o_instret=3.
//  - Write to x0 with data 0xdead -> o_RegWrite=0, o_commit=1, o_instret+1.
//  - csr_RegWrite=1, csr_rdata=0x1800, reg_wr_data=0x5 -> o_reg_wr_data=0x1800.
//  - Fill FIFO (DEPTH=2) under i_stall=1 -> o_ready=0; release -> 2 commits on consecutive cycles.
//  - ecall followed by 1 queued + 1 same-cycle entry -> o_ecall/o_flush pulse, following entries never commit.
//  - timer_intr+ecall same entry, trap_pc=0x80000010 -> o_timer_intr=1, o_ecall=0, o_trap_pc=0x80000010,
//    o_commit=0; assert i_rst_n=0 mid-stream -> all outputs 0 next edge-free cycle, o_ready=1.

Source files
------------

// File: rtl/ysyx_22040386_pkg.sv
// Shared types for the write-back/commit stage: buffered MEM entry layout,
// default widths and the per-entry trap priority encoding.
package ysyx_22040386_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_RA_W = 5;
  localparam int DEF_CA_W = 12;

  typedef enum logic [1:0] {
    TR_NONE  = 2'd0,
    TR_MRET  = 2'd1,
    TR_ECALL = 2'd2,
    TR_INTR  = 2'd3
  } trap_e;

  typedef struct packed {
    logic [31:0]          inst;
    logic [DEF_XLEN-1:0]  pc;
    logic                 reg_write;
    logic [DEF_RA_W-1:0]  reg_wr_addr;
    logic [DEF_XLEN-1:0]  reg_wr_data;
    logic                 csr_reg_write;
    logic [DEF_XLEN-1:0]  csr_rdata;
    logic                 csr_wen;
    logic [DEF_CA_W-1:0]  csr_waddr;
    logic [DEF_XLEN-1:0]  csr_wdata;
    logic                 timer_intr;
    logic                 ecall;
    logic                 mret;
    logic [DEF_XLEN-1:0]  trap_pc;
  } wb_entry_t;

  // Timer interrupt wins over ecall, ecall over mret.
  function automatic trap_e trap_sel(input wb_entry_t e);
    if (e.timer_intr) return TR_INTR;
    if (e.ecall)      return TR_ECALL;
    if (e.mret)       return TR_MRET;
    return TR_NONE;
  endfunction

endpackage

// File: rtl/ysyx_22040386_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; flush empties it and also
// discards any push arriving in the same cycle.
module ysyx_22040386_sync_fifo
  import ysyx_22040386_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  input  logic flush,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ysyx_22040386_wb_commit.sv
// Registered write-back/commit stage: buffers MEM results, resolves traps per
// entry and emits at most one commit per cycle while counting retired instructions.
module ysyx_22040386_wb_commit
  import ysyx_22040386_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int RA_W  = DEF_RA_W,
  parameter int CA_W  = DEF_CA_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_inst,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_RegWrite,
  input  logic [RA_W-1:0]  i_reg_wr_addr,
  input  logic [XLEN-1:0]  i_reg_wr_data,
  input  logic             i_csr_RegWrite,
  input  logic [XLEN-1:0]  i_csr_rdata,
  input  logic             i_csr_wen,
  input  logic [CA_W-1:0]  i_csr_waddr,
  input  logic [XLEN-1:0]  i_csr_wdata,
  input  logic             i_timer_intr,
  input  logic             i_ecall,
  input  logic             i_mret,
  input  logic [XLEN-1:0]  i_trap_pc,
  input  logic             i_stall,
  output logic             o_RegWrite,
  output logic [RA_W-1:0]  o_reg_wr_addr,
  output logic [XLEN-1:0]  o_reg_wr_data,
  output logic             o_csr_wen,
  output logic [CA_W-1:0]  o_csr_waddr,
  output logic [XLEN-1:0]  o_csr_wdata,
  output logic             o_timer_intr,
  output logic             o_ecall,
  output logic             o_mret,
  output logic [XLEN-1:0]  o_trap_pc,
  output logic             o_flush,
  output logic             o_commit,
  output logic [XLEN-1:0]  o_pc,
  output logic [31:0]      o_inst,
  output logic [CNT_W-1:0] o_instret
);

  wb_entry_t in_entry;
  wb_entry_t head;
  trap_e     trap;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      flush;
  logic      normal;

  always_comb begin
    in_entry               = '0;
    in_entry.inst          = i_inst;
    in_entry.pc            = i_pc;
    in_entry.reg_write     = i_RegWrite;
    in_entry.reg_wr_addr   = i_reg_wr_addr;
    in_entry.reg_wr_data   = i_reg_wr_data;
    in_entry.csr_reg_write = i_csr_RegWrite;
    in_entry.csr_rdata     = i_csr_rdata;
    in_entry.csr_wen       = i_csr_wen;
    in_entry.csr_waddr     = i_csr_waddr;
    in_entry.csr_wdata     = i_csr_wdata;
    in_entry.timer_intr    = i_timer_intr;
    in_entry.ecall         = i_ecall;
    in_entry.mret          = i_mret;
    in_entry.trap_pc       = i_trap_pc;
  end

  assign o_ready = !full;
  assign push    = i_valid && o_ready;
  assign pop     = !empty && !i_stall;
  assign trap    = trap_sel(head);
  assign normal  = (trap == TR_NONE);
  // Any trap or mret squashes everything queued behind it, including a same-cycle push.
  assign flush   = pop && !normal;

  ysyx_22040386_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (wb_entry_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Commit register stage: pulses are zero unless an entry is dequeued; data holds otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_RegWrite    <= 1'b0;
      o_reg_wr_addr <= '0;
      o_reg_wr_data <= '0;
      o_csr_wen     <= 1'b0;
      o_csr_waddr   <= '0;
      o_csr_wdata   <= '0;
      o_timer_intr  <= 1'b0;
      o_ecall       <= 1'b0;
      o_mret        <= 1'b0;
      o_trap_pc     <= '0;
      o_flush       <= 1'b0;
      o_commit      <= 1'b0;
      o_pc          <= '0;
      o_inst        <= '0;
      o_instret     <= '0;
    end else begin
      o_commit     <= pop && (trap != TR_INTR);
      o_flush      <= flush;
      o_timer_intr <= pop && (trap == TR_INTR);
      o_ecall      <= pop && (trap == TR_ECALL);
      o_mret       <= pop && (trap == TR_MRET);
      o_RegWrite   <= pop && normal && (head.reg_write || head.csr_reg_write)
                      && (head.reg_wr_addr != '0);
      o_csr_wen    <= pop && normal && head.csr_wen;
      if (pop) begin
        o_reg_wr_addr <= head.reg_wr_addr;
        o_reg_wr_data <= head.csr_reg_write ? head.csr_rdata : head.reg_wr_data;
        o_csr_waddr   <= head.csr_waddr;
        o_csr_wdata   <= head.csr_wdata;
        o_trap_pc     <= head.trap_pc;
        o_pc          <= head.pc;
        o_inst        <= head.inst;
      end
      if (pop && (trap != TR_INTR)) o_instret <= o_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_wb_commit.sv
// Directed bench for the commit stage: hand-computed expectations for normal
// writes, x0 suppression, CSR merge, backpressure, trap flushes and mid-run reset.
module tb_ysyx_22040386_wb_commit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_inst;
  logic [63:0] i_pc;
  logic        i_RegWrite;
  logic [4:0]  i_reg_wr_addr;
  logic [63:0] i_reg_wr_data;
  logic        i_csr_RegWrite;
  logic [63:0] i_csr_rdata;
  logic        i_csr_wen;
  logic [11:0] i_csr_waddr;
  logic [63:0] i_csr_wdata;
  logic        i_timer_intr;
  logic        i_ecall;
  logic        i_mret;
  logic [63:0] i_trap_pc;
  logic        i_stall;
  logic        o_RegWrite;
  logic [4:0]  o_reg_wr_addr;
  logic [63:0] o_reg_wr_data;
  logic        o_csr_wen;
  logic [11:0] o_csr_waddr;
  logic [63:0] o_csr_wdata;
  logic        o_timer_intr;
  logic        o_ecall;
  logic        o_mret;
  logic [63:0] o_trap_pc;
  logic        o_flush;
  logic        o_commit;
  logic [63:0] o_pc;
  logic [31:0] o_inst;
  logic [63:0] o_instret;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  ysyx_22040386_wb_commit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_RegWrite(i_RegWrite),
    .i_reg_wr_addr(i_reg_wr_addr), .i_reg_wr_data(i_reg_wr_data),
    .i_csr_RegWrite(i_csr_RegWrite), .i_csr_rdata(i_csr_rdata),
    .i_csr_wen(i_csr_wen), .i_csr_waddr(i_csr_waddr), .i_csr_wdata(i_csr_wdata),
    .i_timer_intr(i_timer_intr), .i_ecall(i_ecall), .i_mret(i_mret),
    .i_trap_pc(i_trap_pc), .i_stall(i_stall),
    .o_RegWrite(o_RegWrite), .o_reg_wr_addr(o_reg_wr_addr), .o_reg_wr_data(o_reg_wr_data),
    .o_csr_wen(o_csr_wen), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
    .o_timer_intr(o_timer_intr), .o_ecall(o_ecall), .o_mret(o_mret),
    .o_trap_pc(o_trap_pc), .o_flush(o_flush), .o_commit(o_commit),
    .o_pc(o_pc), .o_inst(o_inst), .o_instret(o_instret)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_in();
    i_valid = 0; i_inst = '0; i_pc = '0; i_RegWrite = 0; i_reg_wr_addr = '0;
    i_reg_wr_data = '0; i_csr_RegWrite = 0; i_csr_rdata = '0; i_csr_wen = 0;
    i_csr_waddr = '0; i_csr_wdata = '0; i_timer_intr = 0; i_ecall = 0; i_mret = 0;
    i_trap_pc = '0;
  endtask

  task automatic put_norm(input logic [4:0] addr, input logic [63:0] data, input logic [63:0] pc);
    clear_in();
    i_valid = 1; i_RegWrite = 1; i_reg_wr_addr = addr; i_reg_wr_data = data;
    i_pc = pc; i_inst = 32'h0000_0013 | {20'd0, addr, 7'd0};
  endtask

  initial begin
    clear_in();
    i_stall = 0;
    i_rst_n = 0;
    cyc(); cyc();
    check("rst_commit", o_commit, 0);
    check("rst_ready", o_ready, 1);
    check("rst_instret", o_instret, 0);
    check("rst_data", o_reg_wr_data, 0);
    i_rst_n = 1;

    // three back-to-back normal writes
    put_norm(5'd5, 64'd1, 64'h8000_0000); cyc();
    check("t1_lat_commit", o_commit, 0);
    put_norm(5'd6, 64'd2, 64'h8000_0004); cyc();
    check("t1_a_we", o_RegWrite, 1);
    check("t1_a_addr", o_reg_wr_addr, 5);
    check("t1_a_data", o_reg_wr_data, 1);
    check("t1_a_pc", o_pc, 64'h8000_0000);
    check("t1_a_inst", o_inst, 32'h0000_0293);
    check("t1_a_instret", o_instret, 1);
    put_norm(5'd7, 64'd3, 64'h8000_0008); cyc();
    check("t1_b_addr", o_reg_wr_addr, 6);
    check("t1_b_data", o_reg_wr_data, 2);
    clear_in(); cyc();
    check("t1_c_we", o_RegWrite, 1);
    check("t1_c_addr", o_reg_wr_addr, 7);
    check("t1_c_data", o_reg_wr_data, 3);
    check("t1_instret", o_instret, 3);
    cyc();
    check("t1_idle_commit", o_commit, 0);
    check("t1_idle_we", o_RegWrite, 0);

    // write to x0 is retired but not written
    put_norm(5'd0, 64'hdead, 64'h8000_000c); cyc();
    clear_in(); cyc();
    check("x0_we", o_RegWrite, 0);
    check("x0_commit", o_commit, 1);
    check("x0_instret", o_instret, 4);

    // CSR read value replaces ALU result; CSR write passes through
    clear_in();
    i_valid = 1; i_csr_RegWrite = 1; i_csr_rdata = 64'h1800; i_reg_wr_data = 64'h5;
    i_reg_wr_addr = 5'd10; i_csr_wen = 1; i_csr_waddr = 12'h300; i_csr_wdata = 64'h55;
    cyc();
    clear_in(); cyc();
    check("csr_data", o_reg_wr_data, 64'h1800);
    check("csr_we", o_RegWrite, 1);
    check("csr_wen", o_csr_wen, 1);
    check("csr_waddr", o_csr_waddr, 12'h300);
    check("csr_wdata", o_csr_wdata, 64'h55);
    check("csr_instret", o_instret, 5);

    // fill under stall, third offer must be refused
    i_stall = 1;
    put_norm(5'd8, 64'd8, 64'h8000_0020); cyc();
    check("stall_ready1", o_ready, 1);
    put_norm(5'd9, 64'd9, 64'h8000_0024); cyc();
    check("stall_full", o_ready, 0);
    check("stall_commit", o_commit, 0);
    put_norm(5'd11, 64'd11, 64'h8000_0028); cyc();
    check("stall_full2", o_ready, 0);
    check("stall_we", o_RegWrite, 0);
    check("stall_csrwen", o_csr_wen, 0);
    check("stall_hold", o_reg_wr_addr, 10);
    clear_in(); i_stall = 0; cyc();
    check("rel_a_commit", o_commit, 1);
    check("rel_a_addr", o_reg_wr_addr, 8);
    cyc();
    check("rel_b_commit", o_commit, 1);
    check("rel_b_addr", o_reg_wr_addr, 9);
    check("rel_instret", o_instret, 7);
    cyc();
    check("rel_refused", o_commit, 0);

    // ecall with one entry queued behind it
    i_stall = 1;
    put_norm(5'd13, 64'h77, 64'h8000_0030); i_ecall = 1; i_trap_pc = 64'h8000_0004; cyc();
    put_norm(5'd14, 64'he, 64'h8000_0034); cyc();
    clear_in(); i_stall = 0; cyc();
    check("ec_ecall", o_ecall, 1);
    check("ec_flush", o_flush, 1);
    check("ec_commit", o_commit, 1);
    check("ec_we", o_RegWrite, 0);
    check("ec_trap_pc", o_trap_pc, 64'h8000_0004);
    check("ec_instret", o_instret, 8);
    cyc();
    check("ec_q_commit", o_commit, 0);
    check("ec_flush_pulse", o_flush, 0);
    check("ec_ready", o_ready, 1);
    cyc();
    check("ec_q_commit2", o_commit, 0);

    // ecall with a same-cycle enqueue
    put_norm(5'd13, 64'h78, 64'h8000_0040); i_ecall = 1; i_trap_pc = 64'h8000_0040; cyc();
    put_norm(5'd15, 64'hf, 64'h8000_0044); cyc();
    check("ec2_ecall", o_ecall, 1);
    check("ec2_instret", o_instret, 9);
    clear_in(); cyc();
    check("ec2_drop", o_commit, 0);
    cyc();
    check("ec2_drop2", o_commit, 0);
    check("ec2_instret2", o_instret, 9);

    // timer interrupt beats ecall on the same entry
    put_norm(5'd16, 64'h16, 64'h8000_0050);
    i_timer_intr = 1; i_ecall = 1; i_trap_pc = 64'h8000_0010; cyc();
    clear_in(); cyc();
    check("ti_intr", o_timer_intr, 1);
    check("ti_ecall", o_ecall, 0);
    check("ti_trap_pc", o_trap_pc, 64'h8000_0010);
    check("ti_commit", o_commit, 0);
    check("ti_flush", o_flush, 1);
    check("ti_we", o_RegWrite, 0);
    check("ti_instret", o_instret, 9);

    // mret retires and flushes
    clear_in(); i_valid = 1; i_mret = 1; i_pc = 64'h8000_0060; cyc();
    clear_in(); cyc();
    check("mr_mret", o_mret, 1);
    check("mr_commit", o_commit, 1);
    check("mr_flush", o_flush, 1);
    check("mr_instret", o_instret, 10);

    // reset in the middle of a stream
    put_norm(5'd20, 64'h20, 64'h8000_0070); cyc();
    put_norm(5'd21, 64'h21, 64'h8000_0074); cyc();
    check("mid_pre_commit", o_commit, 1);
    i_rst_n = 0;
    #2;
    check("mid_commit", o_commit, 0);
    check("mid_instret", o_instret, 0);
    check("mid_data", o_reg_wr_data, 0);
    check("mid_pc", o_pc, 0);
    check("mid_we", o_RegWrite, 0);
    check("mid_ready", o_ready, 1);
    clear_in(); cyc();
    i_rst_n = 1;
    cyc(); cyc();
    check("mid_discard", o_commit, 0);
    check("mid_instret2", o_instret, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
